// File: rtl/acc_pkg.sv
// Shared types for the accumulator / serial shifter block.
package acc_pkg;

    typedef enum logic [1:0] {
        ACC_LSL = 2'b00,
        ACC_LSR = 2'b01,
        ACC_ASR = 2'b10,
        ACC_ROR = 2'b11
    } acc_shift_op_e;

    typedef enum logic {
        ACC_IDLE  = 1'b0,
        ACC_SHIFT = 1'b1
    } acc_state_e;

endpackage

// File: rtl/acc_shift_step.sv
// Combinational single-bit shifter; carry_o is the bit that leaves the word.
module acc_shift_step
    import acc_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic [WIDTH-1:0] value_i,
    input  acc_shift_op_e    op_i,
    output logic [WIDTH-1:0] value_o,
    output logic             carry_o
);

    always_comb begin
        value_o = value_i;
        carry_o = value_i[0];
        unique case (op_i)
            ACC_LSL: begin
                value_o = {value_i[WIDTH-2:0], 1'b0};
                carry_o = value_i[WIDTH-1];
            end
            ACC_LSR: value_o = {1'b0, value_i[WIDTH-1:1]};
            ACC_ASR: value_o = {value_i[WIDTH-1], value_i[WIDTH-1:1]};
            ACC_ROR: value_o = {value_i[0], value_i[WIDTH-1:1]};
            default: value_o = value_i;
        endcase
    end

endmodule

// File: rtl/acc_shift_reg.sv
// Accumulator register with a one-bit-per-clock serial shifter, start/busy/done
// handshake, registered read port and zero/negative/carry flags.
//
//   state     | meaning
//   ACC_IDLE  | accepts loads and shift starts; zero-amount shifts complete here
//   ACC_SHIFT | one shift step per edge until cnt reaches 1; loads/starts dropped
module acc_shift_reg
    import acc_pkg::*;
#(
    parameter int WIDTH   = 16,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               acc_clk,
    input  logic               acc_rst,
    input  logic [WIDTH-1:0]   acc_in,
    input  logic               acc_wr_en,
    input  logic               acc_rd_en,
    input  logic               acc_shift_start,
    input  logic [1:0]         acc_shift_op,
    input  logic [SHAMT_W-1:0] acc_shift_amt,
    output logic [WIDTH-1:0]   acc_out,
    output logic               acc_busy,
    output logic               acc_done,
    output logic               acc_zero,
    output logic               acc_neg,
    output logic               acc_carry
);

    acc_state_e         state_q, state_d;
    logic [SHAMT_W-1:0] cnt_q, cnt_d;
    acc_shift_op_e      op_q, op_d;
    logic [WIDTH-1:0]   acc_q, acc_d;
    logic [WIDTH-1:0]   out_q, out_d;
    logic               carry_q, carry_d;
    logic               done_q, done_d;

    logic [WIDTH-1:0]   step_value;
    logic               step_carry;

    acc_shift_step #(.WIDTH(WIDTH)) u_step (
        .value_i (acc_q),
        .op_i    (op_q),
        .value_o (step_value),
        .carry_o (step_carry)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        acc_d   = acc_q;
        carry_d = carry_q;
        done_d  = 1'b0;
        out_d   = acc_rd_en ? acc_q : out_q;

        unique case (state_q)
            ACC_IDLE: begin
                if (acc_wr_en) begin
                    acc_d   = acc_in;
                    carry_d = 1'b0;
                end else if (acc_shift_start) begin
                    op_d = acc_shift_op_e'(acc_shift_op);
                    if (acc_shift_amt == '0) begin
                        done_d = 1'b1;
                    end else begin
                        cnt_d   = acc_shift_amt;
                        state_d = ACC_SHIFT;
                    end
                end
            end
            ACC_SHIFT: begin
                acc_d   = step_value;
                carry_d = step_carry;
                cnt_d   = cnt_q - SHAMT_W'(1);
                if (cnt_q == SHAMT_W'(1)) begin
                    state_d = ACC_IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = ACC_IDLE;
        endcase
    end

    always_ff @(posedge acc_clk or posedge acc_rst) begin
        if (acc_rst) begin
            state_q <= ACC_IDLE;
            cnt_q   <= '0;
            op_q    <= ACC_LSL;
            acc_q   <= '0;
            out_q   <= '0;
            carry_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            acc_q   <= acc_d;
            out_q   <= out_d;
            carry_q <= carry_d;
            done_q  <= done_d;
        end
    end

    assign acc_out   = out_q;
    assign acc_busy  = (state_q == ACC_SHIFT);
    assign acc_done  = done_q;
    assign acc_zero  = (acc_q == '0);
    assign acc_neg   = acc_q[WIDTH-1];
    assign acc_carry = carry_q;

endmodule

// File: tb/tb_acc_shift_reg.sv
// Self-checking bench for acc_shift_reg: directed scenarios plus randomized
// shifts compared against an arithmetic reference model.
module tb_acc_shift_reg;
    import acc_pkg::*;

    localparam int W  = 16;
    localparam int SW = 4;

    logic          acc_clk;
    logic          acc_rst;
    logic [W-1:0]  acc_in;
    logic          acc_wr_en;
    logic          acc_rd_en;
    logic          acc_shift_start;
    logic [1:0]    acc_shift_op;
    logic [SW-1:0] acc_shift_amt;
    logic [W-1:0]  acc_out;
    logic          acc_busy;
    logic          acc_done;
    logic          acc_zero;
    logic          acc_neg;
    logic          acc_carry;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] m_acc;
    logic         m_carry;

    acc_shift_reg #(.WIDTH(W), .SHAMT_W(SW)) dut (
        .acc_clk         (acc_clk),
        .acc_rst         (acc_rst),
        .acc_in          (acc_in),
        .acc_wr_en       (acc_wr_en),
        .acc_rd_en       (acc_rd_en),
        .acc_shift_start (acc_shift_start),
        .acc_shift_op    (acc_shift_op),
        .acc_shift_amt   (acc_shift_amt),
        .acc_out         (acc_out),
        .acc_busy        (acc_busy),
        .acc_done        (acc_done),
        .acc_zero        (acc_zero),
        .acc_neg         (acc_neg),
        .acc_carry       (acc_carry)
    );

    initial acc_clk = 1'b0;
    always #5 acc_clk = ~acc_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge acc_clk);
        #1;
    endtask

    // Reference: an n-bit shift is one arithmetic operation; carry is the last bit out.
    task automatic model_shift(input logic [1:0] op, input int amt);
        if (amt == 0) return;
        case (op)
            2'b00: begin m_carry = m_acc[W-amt]; m_acc = m_acc << amt; end
            2'b01: begin m_carry = m_acc[amt-1]; m_acc = m_acc >> amt; end
            2'b10: begin m_carry = m_acc[amt-1]; m_acc = W'($signed(m_acc) >>> amt); end
            default: begin
                m_carry = m_acc[amt-1];
                m_acc = (m_acc >> amt) | (m_acc << (W - amt));
            end
        endcase
    endtask

    task automatic load(input logic [W-1:0] v);
        acc_in = v;
        acc_wr_en = 1'b1;
        tick();
        acc_wr_en = 1'b0;
        m_acc = v;
        m_carry = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output int busy_cnt, output bit ok);
        busy_cnt = 0;
        ok = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (acc_done) begin
                ok = 1'b1;
                break;
            end
            if (acc_busy) busy_cnt++;
            tick();
        end
    endtask

    task automatic read_check(input string name);
        acc_rd_en = 1'b1;
        tick();
        acc_rd_en = 1'b0;
        n_tests++;
        if (acc_out !== m_acc) begin
            n_fail++;
            $display("FAIL %s read: acc_out=%h expected=%h", name, acc_out, m_acc);
        end
        n_tests++;
        if (acc_done !== 1'b0) begin
            n_fail++;
            $display("FAIL %s done_width: acc_done=%b expected=0", name, acc_done);
        end
    endtask

    task automatic run_shift(input logic [1:0] op, input int amt, input string name);
        int  busy_cnt;
        bit  ok;
        acc_shift_op = op;
        acc_shift_amt = SW'(amt);
        acc_shift_start = 1'b1;
        tick();
        acc_shift_start = 1'b0;
        wait_done(40, busy_cnt, ok);
        model_shift(op, amt);
        n_tests++;
        if (!ok) begin
            n_fail++;
            $display("FAIL %s done_timeout: no done within 40 cycles", name);
        end
        n_tests++;
        if (busy_cnt != amt) begin
            n_fail++;
            $display("FAIL %s busy_len: got %0d expected %0d", name, busy_cnt, amt);
        end
        n_tests++;
        if (acc_busy !== 1'b0) begin
            n_fail++;
            $display("FAIL %s busy_at_done: got %b expected 0", name, acc_busy);
        end
        n_tests++;
        if ({acc_carry, acc_zero, acc_neg} !== {m_carry, (m_acc == '0), m_acc[W-1]}) begin
            n_fail++;
            $display("FAIL %s flags(c,z,n): got %b%b%b expected %b%b%b", name,
                     acc_carry, acc_zero, acc_neg, m_carry, (m_acc == '0), m_acc[W-1]);
        end
    endtask

    task automatic check_reset_outputs(input string name);
        n_tests++;
        if ({acc_out, acc_carry, acc_done, acc_busy, acc_zero, acc_neg} !==
            {{W{1'b0}}, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0}) begin
            n_fail++;
            $display("FAIL %s: out=%h c=%b d=%b b=%b z=%b n=%b expected out=0 c=0 d=0 b=0 z=1 n=0",
                     name, acc_out, acc_carry, acc_done, acc_busy, acc_zero, acc_neg);
        end
    endtask

    task automatic test_reset();
        #7 acc_rst = 1'b1;
        #1 check_reset_outputs("reset_async");
        tick();
        tick();
        check_reset_outputs("reset_held");
        acc_rst = 1'b0;
        m_acc = '0;
        m_carry = 1'b0;
        tick();
        check_reset_outputs("reset_released_idle");
    endtask

    task automatic test_lsl();
        load(16'h8001);
        acc_shift_op = ACC_LSL;
        acc_shift_amt = SW'(3);
        acc_shift_start = 1'b1;
        tick();
        acc_shift_start = 1'b0;
        n_tests++;
        if (acc_busy !== 1'b1) begin
            n_fail++;
            $display("FAIL lsl_busy_e0: got %b expected 1", acc_busy);
        end
        tick();
        n_tests++;
        if (acc_carry !== 1'b1) begin
            n_fail++;
            $display("FAIL lsl_carry_step1: got %b expected 1", acc_carry);
        end
        tick();
        tick();
        n_tests++;
        if ({acc_done, acc_busy, acc_carry} !== 3'b100) begin
            n_fail++;
            $display("FAIL lsl_done(d,b,c): got %b%b%b expected 100", acc_done, acc_busy, acc_carry);
        end
        m_acc = 16'h0008;
        m_carry = 1'b0;
        read_check("lsl_0x8001_by3");
    endtask

    task automatic test_asr_ror();
        load(16'h8000);
        run_shift(ACC_ASR, 15, "asr15");
        n_tests++;
        if (m_acc !== 16'hFFFF || acc_neg !== 1'b1 || acc_carry !== 1'b0) begin
            n_fail++;
            $display("FAIL asr15_result: model=%h neg=%b carry=%b expected FFFF 1 0",
                     m_acc, acc_neg, acc_carry);
        end
        read_check("asr15");
        load(16'h0001);
        run_shift(ACC_ROR, 1, "ror1");
        n_tests++;
        if (acc_carry !== 1'b1 || acc_neg !== 1'b1) begin
            n_fail++;
            $display("FAIL ror1_flags: carry=%b neg=%b expected 1 1", acc_carry, acc_neg);
        end
        read_check("ror1");
    endtask

    task automatic test_zero_amt();
        load(16'h8001);
        run_shift(ACC_LSL, 1, "pre_zero_lsl1");
        run_shift(ACC_ROR, 0, "zero_amt");
        tick();
        n_tests++;
        if ({acc_done, acc_busy, acc_carry} !== 3'b001) begin
            n_fail++;
            $display("FAIL zero_amt_after(d,b,c): got %b%b%b expected 001", acc_done, acc_busy, acc_carry);
        end
        read_check("zero_amt_value");
        acc_in = 16'h1234;
        acc_wr_en = 1'b1;
        acc_shift_start = 1'b1;
        acc_shift_op = ACC_LSL;
        acc_shift_amt = SW'(3);
        tick();
        acc_wr_en = 1'b0;
        acc_shift_start = 1'b0;
        m_acc = 16'h1234;
        m_carry = 1'b0;
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if ({acc_done, acc_busy, acc_carry} !== 3'b000) begin
                n_fail++;
                $display("FAIL load_wins(d,b,c) cycle %0d: got %b%b%b expected 000",
                         i, acc_done, acc_busy, acc_carry);
            end
            tick();
        end
        read_check("load_wins_value");
    endtask

    task automatic test_back_to_back();
        int busy_cnt;
        bit ok;
        load(16'hFFFF);
        acc_shift_op = ACC_LSR;
        acc_shift_amt = SW'(8);
        acc_shift_start = 1'b1;
        tick();
        busy_cnt = 0;
        for (int i = 0; i < 3; i++) begin
            if (acc_busy) busy_cnt++;
            acc_shift_start = 1'b1;
            acc_shift_op = ACC_LSL;
            acc_shift_amt = SW'(2);
            acc_wr_en = 1'b1;
            acc_in = 16'h0000;
            tick();
        end
        acc_shift_start = 1'b0;
        acc_wr_en = 1'b0;
        begin
            int rest;
            wait_done(40, rest, ok);
            busy_cnt += rest;
        end
        model_shift(ACC_LSR, 8);
        n_tests++;
        if (!ok || busy_cnt != 8 || acc_carry !== m_carry) begin
            n_fail++;
            $display("FAIL ignore_during_busy: done=%b busy=%0d carry=%b expected done=1 busy=8 carry=%b",
                     ok, busy_cnt, acc_carry, m_carry);
        end
        acc_shift_start = 1'b1;
        acc_shift_op = ACC_LSR;
        acc_shift_amt = SW'(4);
        acc_rd_en = 1'b1;
        tick();
        acc_shift_start = 1'b0;
        acc_rd_en = 1'b0;
        n_tests++;
        if (acc_busy !== 1'b1 || acc_out !== 16'h00FF) begin
            n_fail++;
            $display("FAIL b2b_start: busy=%b out=%h expected busy=1 out=00FF", acc_busy, acc_out);
        end
        wait_done(40, busy_cnt, ok);
        model_shift(ACC_LSR, 4);
        n_tests++;
        if (!ok || busy_cnt != 4 || acc_carry !== m_carry) begin
            n_fail++;
            $display("FAIL b2b_second: done=%b busy=%0d carry=%b expected done=1 busy=4 carry=%b",
                     ok, busy_cnt, acc_carry, m_carry);
        end
        read_check("b2b_result");
    endtask

    task automatic test_reset_mid_shift();
        load(16'hFFFF);
        acc_shift_op = ACC_LSR;
        acc_shift_amt = SW'(8);
        acc_shift_start = 1'b1;
        tick();
        acc_shift_start = 1'b0;
        for (int i = 0; i < 3; i++) tick();
        acc_rst = 1'b1;
        #1 check_reset_outputs("reset_mid_immediate");
        tick();
        acc_rst = 1'b0;
        m_acc = '0;
        m_carry = 1'b0;
        for (int i = 0; i < 10; i++) begin
            n_tests++;
            if (acc_done !== 1'b0 || acc_busy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_no_done cycle %0d: done=%b busy=%b expected 0 0",
                         i, acc_done, acc_busy);
            end
            tick();
        end
        read_check("reset_mid_cleared");
        load(16'hA5C3);
        run_shift(ACC_ROR, 5, "after_reset_shift");
        read_check("after_reset_shift");
    endtask

    task automatic test_random();
        logic [1:0] op;
        int         amt;
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(0, 1) == 1) load(W'($urandom));
            op  = 2'($urandom_range(0, 3));
            amt = int'($urandom_range(0, W - 1));
            run_shift(op, amt, $sformatf("rand%0d_op%0d_amt%0d", i, op, amt));
            if ($urandom_range(0, 2) != 0) read_check($sformatf("rand%0d", i));
        end
    endtask

    initial begin
        acc_rst = 1'b0;
        acc_in = '0;
        acc_wr_en = 1'b0;
        acc_rd_en = 1'b0;
        acc_shift_start = 1'b0;
        acc_shift_op = 2'b00;
        acc_shift_amt = '0;
        m_acc = '0;
        m_carry = 1'b0;

        test_reset();
        test_lsl();
        test_asr_ror();
        test_zero_amt();
        test_back_to_back();
        test_reset_mid_shift();
        test_random();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
